// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUS_IF = 2'd1,
      BUS_D  = 2'd2,
      DONE   = 2'd3
   } bus_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam logic [31:0] ERR_RDATA      = 32'hDEADBEEF;
   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned TIMEOUT_DEF    = 255;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts bus cycles without a memory acknowledge; flags the last allowed cycle.
module bus_timeout_ctr
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // Expiry fires on the cycle the count would reach TIMEOUT, so the bus
   // stays busy for exactly TIMEOUT cycles.
   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 8'd0;
      end else if (enable) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign expired = enable && (cnt_q == LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory bus, with
// fetch anti-starvation and a bus timeout that completes with an error.
module mem_port_arbiter
   import mips_bus_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   bus_state_e  state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [3:0]  starve_q, starve_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        err_q, err_d;
   logic        in_bus;
   logic        tmo_clear, tmo_enable, tmo_expired;

   assign in_bus     = (state_q == BUS_IF) || (state_q == BUS_D);
   assign tmo_enable = in_bus && !mem_ack;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      starve_d   = starve_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      err_d      = err_q;
      tmo_clear  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A saturated counter only defers data while fetch is actually waiting.
            if (d_req && ((starve_q < STARVE_LIM) || !if_req)) begin
               state_d   = BUS_D;
               owner_d   = OWN_D;
               addr_d    = d_addr;
               wdata_d   = d_wdata;
               we_d      = d_we;
               err_d     = 1'b0;
               tmo_clear = 1'b1;
               if (if_req) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (if_req) begin
               state_d   = BUS_IF;
               owner_d   = OWN_IF;
               addr_d    = if_addr;
               wdata_d   = 32'd0;
               we_d      = 1'b0;
               err_d     = 1'b0;
               tmo_clear = 1'b1;
               starve_d  = 4'd0;
            end
         end
         BUS_IF, BUS_D: begin
            if (mem_ack) begin
               state_d = DONE;
               if (owner_q == OWN_IF) begin
                  if_rdata_d = mem_rdata;
               end else begin
                  d_rdata_d = mem_rdata;
               end
            end else if (tmo_expired) begin
               state_d = DONE;
               err_d   = 1'b1;
               if (owner_q == OWN_IF) begin
                  if_rdata_d = ERR_RDATA;
               end else begin
                  d_rdata_d = ERR_RDATA;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         starve_q   <= 4'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         we_q       <= 1'b0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         err_q      <= err_d;
      end
   end

   bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   assign mem_req   = in_bus;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_done   = (state_q == DONE) && (owner_q == OWN_IF);
   assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
   assign err       = (state_q == DONE) && err_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with STARVE_MAX=4 and TIMEOUT=8.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        err;

   int checks;
   int failures;

   mem_port_arbiter #(
      .STARVE_MAX (4),
      .TIMEOUT    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      tick();
      tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
      checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL reset_if_done got=%0b exp=0", if_done); end
      checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL reset_d_done got=%0b exp=0", d_done); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
      checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (if_rdata !== 32'd0) begin failures++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
      checks++; if (d_rdata !== 32'd0) begin failures++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
      reset = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%0b exp=0", mem_req); end
   endtask

   task automatic test_load();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      tick();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL load_mem_req got=%0b exp=1", mem_req); end
      checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL load_mem_addr got=%h exp=40", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL load_mem_we1 got=%0b exp=0", mem_we); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL load_wait req=%0b we=%0b exp=1/0", mem_req, mem_we); end
      tick();
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL load_mem_we3 got=%0b exp=0", mem_we); end
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      checks++; if (d_done !== 1'b1) begin failures++; $display("FAIL load_d_done got=%0b exp=1", d_done); end
      checks++; if (d_rdata !== 32'h12345678) begin failures++; $display("FAIL load_d_rdata got=%h exp=12345678", d_rdata); end
      checks++; if (mem_req !== 1'b0 || if_done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL load_done_side req=%0b if_done=%0b err=%0b exp=0/0/0", mem_req, if_done, err); end
      mem_ack = 1'b0; mem_rdata = 32'hFFFF0000; d_req = 1'b0;
      tick();
      checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL load_done_pulse got=%0b exp=0", d_done); end
      checks++; if (d_rdata !== 32'h12345678) begin failures++; $display("FAIL load_rdata_hold got=%h exp=12345678", d_rdata); end
   endtask

   task automatic test_store();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
      tick();
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL store_mem_we got=%0b exp=1", mem_we); end
      checks++; if (mem_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL store_wdata got=%h exp=cafef00d", mem_wdata); end
      checks++; if (mem_addr !== 32'h80) begin failures++; $display("FAIL store_addr got=%h exp=80", mem_addr); end
      // Requester withdraws and changes data after grant; transaction must survive.
      d_req = 1'b0; d_we = 1'b0; d_wdata = 32'd0; d_addr = 32'd0;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL store_hold req=%0b we=%0b exp=1/1", mem_req, mem_we); end
      checks++; if (mem_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL store_wdata_hold got=%h exp=cafef00d", mem_wdata); end
      mem_ack = 1'b1; mem_rdata = 32'h0;
      tick();
      checks++; if (d_done !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL store_done d_done=%0b req=%0b exp=1/0", d_done, mem_req); end
      mem_ack = 1'b0;
      tick();
      checks++; if (d_done !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL store_idle d_done=%0b req=%0b exp=0/0", d_done, mem_req); end
   endtask

   task automatic test_starve();
      bit          exp_is_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] exp_addr;
      logic [31:0] exp_rd;
      if_req = 1'b1; if_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int g = 0; g < 6; g++) begin
         tick();
         exp_addr = exp_is_d[g] ? 32'h100 : 32'h200;
         checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL starve_req g=%0d got=%0b exp=1", g, mem_req); end
         checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL starve_order g=%0d got=%h exp=%h", g, mem_addr, exp_addr); end
         tick();
         exp_rd = 32'hA0000000 + 32'(g);
         mem_ack = 1'b1; mem_rdata = exp_rd;
         tick();
         checks++; if (d_done !== exp_is_d[g] || if_done !== !exp_is_d[g]) begin failures++; $display("FAIL starve_done g=%0d d=%0b if=%0b exp_d=%0b", g, d_done, if_done, exp_is_d[g]); end
         if (exp_is_d[g]) begin
            checks++; if (d_rdata !== exp_rd) begin failures++; $display("FAIL starve_d_rdata g=%0d got=%h exp=%h", g, d_rdata, exp_rd); end
         end else begin
            checks++; if (if_rdata !== exp_rd) begin failures++; $display("FAIL starve_if_rdata g=%0d got=%h exp=%h", g, if_rdata, exp_rd); end
         end
         mem_ack = 1'b0;
         if (g == 5) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      if_req = 1'b1; if_addr = 32'h300;
      tick();
      checks++; if (mem_addr !== 32'h300 || mem_we !== 1'b0) begin failures++; $display("FAIL tmo_addr addr=%h we=%0b exp=300/0", mem_addr, mem_we); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (mem_req !== 1'b1 || if_done !== 1'b0) begin failures++; $display("FAIL tmo_busy cyc=%0d req=%0b done=%0b exp=1/0", i, mem_req, if_done); end
         tick();
      end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL tmo_req_drop got=%0b exp=0", mem_req); end
      checks++; if (if_done !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL tmo_done if_done=%0b err=%0b exp=1/1", if_done, err); end
      checks++; if (if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL tmo_rdata got=%h exp=deadbeef", if_rdata); end
      checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL tmo_d_done got=%0b exp=0", d_done); end
      if_req = 1'b0;
      tick();
      checks++; if (err !== 1'b0 || if_done !== 1'b0) begin failures++; $display("FAIL tmo_after err=%0b if_done=%0b exp=0/0", err, if_done); end
      checks++; if (if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL tmo_rdata_hold got=%h exp=deadbeef", if_rdata); end
   endtask

   task automatic test_reset_mid();
      if_req = 1'b1; if_addr = 32'h600;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      // Three data grants with fetch waiting leave the starvation count at 3.
      for (int g = 0; g < 3; g++) begin
         tick();
         checks++; if (mem_addr !== 32'h500) begin failures++; $display("FAIL pump_addr g=%0d got=%h exp=500", g, mem_addr); end
         mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
         tick();
         mem_ack = 1'b0;
         tick();
      end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin failures++; $display("FAIL rmid_bus req=%0b addr=%h exp=1/500", mem_req, mem_addr); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmid_req_async got=%0b exp=0", mem_req); end
      checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", mem_addr); end
      checks++; if (d_rdata !== 32'd0 || if_rdata !== 32'd0) begin failures++; $display("FAIL rmid_rdata d=%h if=%h exp=0/0", d_rdata, if_rdata); end
      tick();
      reset = 1'b1;
      tick();
      // Starvation count was cleared, so data wins the first arbitration.
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin failures++; $display("FAIL rmid_first req=%0b addr=%h exp=1/500", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();
      checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL rmid_d_done done=%0b rdata=%h exp=1/0badf00d", d_done, d_rdata); end
      mem_ack = 1'b0; d_req = 1'b0;
      tick();
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin failures++; $display("FAIL rmid_if_grant req=%0b addr=%h exp=1/600", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h600D600D;
      tick();
      checks++; if (if_done !== 1'b1 || if_rdata !== 32'h600D600D || err !== 1'b0) begin failures++; $display("FAIL rmid_if_done done=%0b rdata=%h err=%0b exp=1/600d600d/0", if_done, if_rdata, err); end
      mem_ack = 1'b0; if_req = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_load();
      test_store();
      test_starve();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
